prbs16_checker: RTL and testbench
=================================

Name: prbs16_checker

Overview:
- Receive-side counterpart of the team's 16-bit LFSR pattern generator (taps 16/14/13/11, default seed 16'hACE1).
- Takes the generator's serial output one bit per valid cycle and self-synchronises a local 16-bit history to it.
- Once locked, predicts each incoming bit and reports lock status, bit-error count and checked-bit count for link/BIST test.

Parameters:
TAPS, 16'hB400, feedback mask; bit i set means the bit received i+1 valid-cycles ago feeds the XOR prediction. Default selects delays 16, 14, 13 and 11.
LOCK_N, 32, consecutive correct predictions required in VERIFY before declaring lock (1..255).
WINDOW, 256, valid bits per loss-of-lock evaluation window while locked (2..65535).
ERR_LIMIT, 16, errors within one window that force loss of lock (1..WINDOW).

Ports:
CLK  in  1  clock, rising edge
n_RESET  in  1  reset, asynchronous, active-low
D_IN  in  1  received serial bit
D_VALID  in  1  D_IN valid this cycle; all state frozen when low (except CLR_CNT)
CLR_CNT  in  1  synchronous clear of ERR_CNT and BIT_CNT
LOCKED  out  1  checker is in LOCKED state
ERR_PULSE  out  1  one-cycle pulse: mismatch detected while locked
ERR_CNT  out  16  saturating count of mismatches while locked
BIT_CNT  out  32  saturating count of bits checked while locked

Behaviour:
- Reset (asynchronous, n_RESET=0):
  - state=SEARCH; history H=0; fill/match/window counters=0.
  - LOCKED=0, ERR_PULSE=0, ERR_CNT=0, BIT_CNT=0.
  - Applies immediately and from any state, including mid-lock.
- History H[15:0]: H[0] is the newest bit. Prediction P = XOR-reduce(H & TAPS), combinational from the current H.
- All outputs registered. Every state change takes effect on the CLK edge where D_VALID=1.
- SEARCH:
  - Each valid bit: H <= {H[14:0], D_IN}; fill count +1.
  - After the 16th valid bit -> VERIFY, with match count=0.
- VERIFY:
  - Each valid bit: H <= {H[14:0], D_IN} (self-sync, always loads the received bit).
  - Match when D_IN==P and H!=0. All-zero history always counts as a mismatch.
  - Match: match count +1. When the LOCK_N-th consecutive match is registered -> LOCKED; LOCKED=1 from that edge.
  - Mismatch: match count=0; stay in VERIFY.
- LOCKED (flywheel):
  - Each valid bit: H <= {H[14:0], P}. The predicted bit is loaded, not D_IN, so one line error produces exactly one counted error.
  - BIT_CNT +1, saturating at 32'hFFFFFFFF.
  - Window count +1.
  - If D_IN != P: ERR_PULSE=1 for that one cycle; ERR_CNT +1, saturating at 16'hFFFF; window error count +1.
  - Window error count reaching ERR_LIMIT on this bit -> SEARCH: fill count=0, H=0, LOCKED=0 on the same edge. The bit that triggers the loss is still counted in BIT_CNT and ERR_CNT.
  - When window count reaches WINDOW without loss: window count=0 and window error count=0. The errors of the last bit are included in the window they close.
- ERR_PULSE is 0 in any cycle with no valid mismatch, and always 0 outside LOCKED.
- CLR_CNT=1:
  - ERR_CNT and BIT_CNT <= 0. Clear wins over a same-cycle increment.
  - Does not affect state, H or window counters.
  - Works with D_VALID=0.
- Counters are not cleared by loss or regain of lock; only reset or CLR_CNT clears them.
- Latency: a mismatching bit at edge k gives ERR_PULSE and the updated ERR_CNT visible after edge k.
- Minimum time to lock from reset with a clean stream: 16 + LOCK_N valid bits (48 with defaults).

Test Plan:
- Clean lock: reset, then stream from a reference generator (recurrence b[k] = b[k-16]^b[k-14]^b[k-13]^b[k-11], seeded 16'hACE1), D_VALID=1 continuously -> LOCKED rises after the 48th bit edge; ERR_CNT=0 and ERR_PULSE never high after 1000 bits; BIT_CNT=952.
- Single error: lock, then invert bit 200 only -> exactly one ERR_PULSE, on that bit's edge; ERR_CNT=1; LOCKED stays 1.
- Loss of lock: lock, then invert 16 bits within one 256-bit window -> LOCKED falls on the 16th error edge; ERR_CNT=16; relock after a further 48 clean bits.
- Window expiry: lock, then 15 errors in window 1 and 15 errors in window 2 -> LOCKED stays 1; ERR_CNT=30.
- Gapped valid / clear / zero input:
  - Randomly deassert D_VALID (50%) -> lock timing and counts identical in valid-bit terms.
  - Pulse CLR_CNT on an error cycle -> ERR_CNT=0 afterwards.
  - All-zero input -> never locks.
- Async reset mid-lock: assert n_RESET=0 between edges -> LOCKED, ERR_CNT and BIT_CNT go to 0 immediately; relock after 48 bits following release.

Source files
------------

// File: rtl/prbs16_checker.sv
// Self-synchronising checker for the 16-bit LFSR pattern generator.
// Locks onto the serial stream, then flywheels and counts bit errors.
module prbs16_checker #(
  parameter logic [15:0] TAPS      = 16'hB400,
  parameter int          LOCK_N    = 32,
  parameter int          WINDOW    = 256,
  parameter int          ERR_LIMIT = 16
) (
  input  logic        CLK,
  input  logic        n_RESET,
  input  logic        D_IN,
  input  logic        D_VALID,
  input  logic        CLR_CNT,
  output logic        LOCKED,
  output logic        ERR_PULSE,
  output logic [15:0] ERR_CNT,
  output logic [31:0] BIT_CNT
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] h_reg, h_next;
  logic [4:0]  fill_reg, fill_next;
  logic [7:0]  match_reg, match_next;
  logic [15:0] win_cnt_reg, win_cnt_next;
  logic [15:0] win_err_reg, win_err_next;
  logic        locked_reg, locked_next;
  logic        pulse_reg, pulse_next;
  logic [15:0] err_cnt_reg, err_cnt_next;
  logic [31:0] bit_cnt_reg, bit_cnt_next;

  logic [15:0] tapped;
  logic        pred;
  logic [16:0] win_cnt_inc;
  logic [16:0] win_err_inc;
  logic        bit_err;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_tap
      assign tapped[gi] = h_reg[gi] & TAPS[gi];
    end
  endgenerate

  assign pred        = ^tapped;
  assign bit_err     = D_IN != pred;
  assign win_cnt_inc = {1'b0, win_cnt_reg} + 17'd1;
  assign win_err_inc = {1'b0, win_err_reg} + 17'd1;

  always_comb begin
    state_next   = state_reg;
    h_next       = h_reg;
    fill_next    = fill_reg;
    match_next   = match_reg;
    win_cnt_next = win_cnt_reg;
    win_err_next = win_err_reg;
    pulse_next   = 1'b0;
    err_cnt_next = err_cnt_reg;
    bit_cnt_next = bit_cnt_reg;

    if (D_VALID) begin
      case (state_reg)
        S_SEARCH: begin
          h_next    = {h_reg[14:0], D_IN};
          fill_next = fill_reg + 5'd1;
          if (fill_reg == 5'd15) begin
            state_next = S_VERIFY;
            match_next = 8'd0;
          end
        end

        S_VERIFY: begin
          h_next = {h_reg[14:0], D_IN};
          // An all-zero history predicts zeros forever, so it never counts as a match.
          if (!bit_err && (h_reg != 16'd0)) begin
            if (match_reg == 8'(LOCK_N - 1)) begin
              state_next   = S_LOCKED;
              match_next   = 8'd0;
              win_cnt_next = 16'd0;
              win_err_next = 16'd0;
            end else begin
              match_next = match_reg + 8'd1;
            end
          end else begin
            match_next = 8'd0;
          end
        end

        S_LOCKED: begin
          // Flywheel: load the prediction so a line error is not propagated.
          h_next       = {h_reg[14:0], pred};
          win_cnt_next = win_cnt_inc[15:0];
          if (bit_cnt_reg != 32'hFFFF_FFFF) bit_cnt_next = bit_cnt_reg + 32'd1;
          if (bit_err) begin
            pulse_next   = 1'b1;
            win_err_next = win_err_inc[15:0];
            if (err_cnt_reg != 16'hFFFF) err_cnt_next = err_cnt_reg + 16'd1;
          end
          if (bit_err && (win_err_inc == 17'(ERR_LIMIT))) begin
            state_next   = S_SEARCH;
            h_next       = 16'd0;
            fill_next    = 5'd0;
            win_cnt_next = 16'd0;
            win_err_next = 16'd0;
          end else if (win_cnt_inc == 17'(WINDOW)) begin
            win_cnt_next = 16'd0;
            win_err_next = 16'd0;
          end
        end

        default: begin
          state_next = S_SEARCH;
          h_next     = 16'd0;
          fill_next  = 5'd0;
        end
      endcase
    end

    if (CLR_CNT) begin
      err_cnt_next = 16'd0;
      bit_cnt_next = 32'd0;
    end

    locked_next = (state_next == S_LOCKED);
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state_reg   <= S_SEARCH;
      h_reg       <= 16'd0;
      fill_reg    <= 5'd0;
      match_reg   <= 8'd0;
      win_cnt_reg <= 16'd0;
      win_err_reg <= 16'd0;
      locked_reg  <= 1'b0;
      pulse_reg   <= 1'b0;
      err_cnt_reg <= 16'd0;
      bit_cnt_reg <= 32'd0;
    end else begin
      state_reg   <= state_next;
      h_reg       <= h_next;
      fill_reg    <= fill_next;
      match_reg   <= match_next;
      win_cnt_reg <= win_cnt_next;
      win_err_reg <= win_err_next;
      locked_reg  <= locked_next;
      pulse_reg   <= pulse_next;
      err_cnt_reg <= err_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  assign LOCKED    = locked_reg;
  assign ERR_PULSE = pulse_reg;
  assign ERR_CNT   = err_cnt_reg;
  assign BIT_CNT   = bit_cnt_reg;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker driven by a reference PRBS stream.
module tb_prbs16_checker;

  logic        CLK;
  logic        n_RESET;
  logic        D_IN;
  logic        D_VALID;
  logic        CLR_CNT;
  logic        LOCKED;
  logic        ERR_PULSE;
  logic [15:0] ERR_CNT;
  logic [31:0] BIT_CNT;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  int pulse_cnt = 0;
  int lock_seen = 0;
  logic stream [0:1999];
  logic [15:0] seed;

  prbs16_checker dut (
    .CLK      (CLK),
    .n_RESET  (n_RESET),
    .D_IN     (D_IN),
    .D_VALID  (D_VALID),
    .CLR_CNT  (CLR_CNT),
    .LOCKED   (LOCKED),
    .ERR_PULSE(ERR_PULSE),
    .ERR_CNT  (ERR_CNT),
    .BIT_CNT  (BIT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic clr);
    @(negedge CLK);
    D_IN    = d;
    D_VALID = v;
    CLR_CNT = clr;
    @(posedge CLK);
    #1;
    if (ERR_PULSE === 1'b1) pulse_cnt++;
    if (LOCKED === 1'b1) lock_seen++;
  endtask

  // Sends the next reference bit (optionally inverted); idx counts bits sent, 1-based after the call.
  task automatic send(input logic flip, input logic clr);
    step(stream[idx] ^ flip, 1'b1, clr);
    idx++;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    n_RESET = 1'b0;
    D_VALID = 1'b0;
    CLR_CNT = 1'b0;
    D_IN    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_RESET   = 1'b1;
    idx       = 0;
    pulse_cnt = 0;
    lock_seen = 0;
  endtask

  initial begin
    seed = 16'hACE1;
    for (int k = 0; k < 2000; k++) begin
      if (k < 16) stream[k] = seed[k];
      else stream[k] = stream[k-16] ^ stream[k-14] ^ stream[k-13] ^ stream[k-11];
    end
    n_RESET = 1'b1;
    D_IN    = 1'b0;
    D_VALID = 1'b0;
    CLR_CNT = 1'b0;

    // Reset state and clean lock
    do_reset();
    check("rst_locked", 32'(LOCKED), 0);
    check("rst_pulse", 32'(ERR_PULSE), 0);
    check("rst_errcnt", 32'(ERR_CNT), 0);
    check("rst_bitcnt", BIT_CNT, 0);
    for (int k = 1; k <= 1000; k++) begin
      send(1'b0, 1'b0);
      if (k == 47) check("clean_lock_47", 32'(LOCKED), 0);
      if (k == 48) check("clean_lock_48", 32'(LOCKED), 1);
    end
    check("clean_errcnt", 32'(ERR_CNT), 0);
    check("clean_pulses", pulse_cnt, 0);
    check("clean_bitcnt", BIT_CNT, 952);
    $display("clean lock: locked=%0d err=%0d bits=%0d", LOCKED, ERR_CNT, BIT_CNT);

    // Single error at bit 200
    do_reset();
    for (int k = 1; k <= 199; k++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("single_pulse_on", 32'(ERR_PULSE), 1);
    check("single_errcnt_now", 32'(ERR_CNT), 1);
    send(1'b0, 1'b0);
    check("single_pulse_off", 32'(ERR_PULSE), 0);
    for (int k = 202; k <= 300; k++) send(1'b0, 1'b0);
    check("single_pulses", pulse_cnt, 1);
    check("single_errcnt", 32'(ERR_CNT), 1);
    check("single_locked", 32'(LOCKED), 1);
    $display("single error: pulses=%0d err=%0d locked=%0d", pulse_cnt, ERR_CNT, LOCKED);

    // Loss of lock: 16 errors on bits 60..75, relock at bit 123
    do_reset();
    for (int k = 1; k <= 59; k++) send(1'b0, 1'b0);
    for (int k = 60; k <= 75; k++) begin
      send(1'b1, 1'b0);
      if (k == 74) check("loss_locked_74", 32'(LOCKED), 1);
    end
    check("loss_locked_75", 32'(LOCKED), 0);
    check("loss_errcnt", 32'(ERR_CNT), 16);
    check("loss_bitcnt", BIT_CNT, 27);
    check("loss_pulses", pulse_cnt, 16);
    for (int k = 76; k <= 123; k++) begin
      send(1'b0, 1'b0);
      if (k == 122) check("relock_122", 32'(LOCKED), 0);
    end
    check("relock_123", 32'(LOCKED), 1);
    $display("loss of lock: err=%0d bits=%0d locked=%0d", ERR_CNT, BIT_CNT, LOCKED);

    // Window expiry: 15 errors in each of two windows
    do_reset();
    for (int k = 1; k <= 600; k++) begin
      send(((k >= 100 && k <= 114) || (k >= 400 && k <= 414)) ? 1'b1 : 1'b0, 1'b0);
      if (k == 114) check("win1_locked", 32'(LOCKED), 1);
    end
    check("win_locked", 32'(LOCKED), 1);
    check("win_errcnt", 32'(ERR_CNT), 30);
    check("win_bitcnt", BIT_CNT, 552);
    $display("window expiry: err=%0d bits=%0d locked=%0d", ERR_CNT, BIT_CNT, LOCKED);

    // Gapped valid
    do_reset();
    for (int c = 0; c < 2000 && idx < 100; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b0, 1'b0);
        if (idx == 47) check("gap_lock_47", 32'(LOCKED), 0);
        if (idx == 48) check("gap_lock_48", 32'(LOCKED), 1);
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
    end
    check("gap_valid_bits", idx, 100);
    check("gap_bitcnt", BIT_CNT, 52);
    check("gap_errcnt", 32'(ERR_CNT), 0);
    $display("gapped valid: bits=%0d err=%0d locked=%0d", BIT_CNT, ERR_CNT, LOCKED);

    // Clear on an error cycle, then clear with D_VALID low
    send(1'b1, 1'b1);
    check("clr_pulse", 32'(ERR_PULSE), 1);
    check("clr_errcnt", 32'(ERR_CNT), 0);
    check("clr_bitcnt", BIT_CNT, 0);
    check("clr_locked", 32'(LOCKED), 1);
    send(1'b1, 1'b0);
    check("clr_errcnt_after", 32'(ERR_CNT), 1);
    step(1'b0, 1'b0, 1'b1);
    check("clr_novalid_errcnt", 32'(ERR_CNT), 0);
    check("clr_novalid_bitcnt", BIT_CNT, 0);
    $display("clear: err=%0d bits=%0d", ERR_CNT, BIT_CNT);

    // All-zero input never locks
    do_reset();
    for (int k = 1; k <= 200; k++) step(1'b0, 1'b1, 1'b0);
    check("zero_lock_seen", lock_seen, 0);
    check("zero_errcnt", 32'(ERR_CNT), 0);
    $display("zero input: lock_cycles=%0d", lock_seen);

    // Asynchronous reset mid-lock
    do_reset();
    for (int k = 1; k <= 100; k++) send(k == 80 ? 1'b1 : 1'b0, 1'b0);
    check("arst_pre_locked", 32'(LOCKED), 1);
    check("arst_pre_bitcnt", BIT_CNT, 52);
    @(negedge CLK);
    #2;
    n_RESET = 1'b0;
    #1;
    check("arst_locked", 32'(LOCKED), 0);
    check("arst_errcnt", 32'(ERR_CNT), 0);
    check("arst_bitcnt", BIT_CNT, 0);
    @(negedge CLK);
    n_RESET = 1'b1;
    idx = 0;
    for (int k = 1; k <= 48; k++) begin
      send(1'b0, 1'b0);
      if (k == 47) check("arst_relock_47", 32'(LOCKED), 0);
    end
    check("arst_relock_48", 32'(LOCKED), 1);
    $display("async reset: relocked=%0d", LOCKED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
